// File: rtl/bus_drive_sequencer.sv
// bus_drive_sequencer
//   Registered front end for an octal tri-state bus driver that is split into two 4-bit groups.
//   Each group has its own active-low output enable. On an accepted request the byte is
//   captured and held on the driver A inputs. The enables then run through setup, drive and
//   turnaround phases, so that bus drivers never overlap.
//
//   Optional feature (macro BUS_DRV_ABORT_EN): adds the abort input and the sticky aborted
//   output. An abort in SETUP or DRIVE cuts the drive phase short.
//
// Ports
//   sysclk     in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   req        in   start a drive cycle (sampled only in IDLE)
//   data_in    in   [7:0] byte to drive, captured on acceptance
//   grp_sel    in   [1:0] bit0 = group 1 (low nibble), bit1 = group 2 (high nibble)
//   abort      in   (BUS_DRV_ABORT_EN) abandon the drive phase
//   aborted    out  (BUS_DRV_ABORT_EN) sticky, set by abort, cleared on next acceptance
//   busy       out  high from acceptance until return to IDLE
//   done       out  one-cycle pulse in the final cycle before IDLE
//   drv_a      out  [7:0] driver A inputs; [3:0] group 1, [7:4] group 2
//   oe1_n      out  group 1 enable (1G_n), active low
//   oe2_n      out  group 2 enable (2G_n), active low
module bus_drive_sequencer #(
    parameter int DRIVE_CYCLES = 2,
    parameter int TURN_CYCLES  = 1
) (
    input  logic       sysclk,
    input  logic       sys_rst_n,
    input  logic       req,
    input  logic [7:0] data_in,
    input  logic [1:0] grp_sel,
`ifdef BUS_DRV_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] drv_a,
    output logic       oe1_n,
    output logic       oe2_n
);

    if (DRIVE_CYCLES < 1 || DRIVE_CYCLES > 15) begin : gBadDriveCycles
        $error("bus_drive_sequencer: DRIVE_CYCLES must be in 1..15");
    end
    if (TURN_CYCLES < 0 || TURN_CYCLES > 7) begin : gBadTurnCycles
        $error("bus_drive_sequencer: TURN_CYCLES must be in 0..7");
    end

    localparam bit         HasTurn   = (TURN_CYCLES > 0);
    localparam logic [3:0] DriveLoad = 4'(DRIVE_CYCLES - 1);
    localparam logic [3:0] TurnLoad  = HasTurn ? 4'(TURN_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StSetup, StDrive, StTurn} stateT;

    stateT      stateQ, stateD;
    logic [3:0] cntQ, cntD;
    logic [1:0] grpQ, grpD;
    logic [7:0] drvQ, drvD;
    logic       abortedQ, abortedD;
    logic       busyQ, busyD;
    logic       doneQ, doneD;
    logic       oe1Q, oe1D;
    logic       oe2Q, oe2D;
    logic       lastD;

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        grpD     = grpQ;
        drvD     = drvQ;
        abortedD = abortedQ;

        unique case (stateQ)
            StIdle: begin
                // A request with no group selected has nothing to drive, so it is dropped.
                if (req && grp_sel != 2'b00) begin
                    stateD   = StSetup;
                    drvD     = data_in;
                    grpD     = grp_sel;
                    abortedD = 1'b0;
                end
            end
            StSetup: begin
                stateD = StDrive;
                cntD   = DriveLoad;
            end
            StDrive: begin
                if (cntQ == 4'd0) begin
                    stateD = HasTurn ? StTurn : StIdle;
                    cntD   = TurnLoad;
                end else begin
                    cntD = cntQ - 4'd1;
                end
            end
            StTurn: begin
                if (cntQ == 4'd0) begin
                    stateD = StIdle;
                end else begin
                    cntD = cntQ - 4'd1;
                end
            end
            default: begin
                stateD = StIdle;
                cntD   = 4'd0;
            end
        endcase

`ifdef BUS_DRV_ABORT_EN
        if (abort && (stateQ == StSetup || stateQ == StDrive)) begin
            stateD   = HasTurn ? StTurn : StIdle;
            cntD     = TurnLoad;
            abortedD = 1'b1;
        end
`endif

        // All outputs are registered copies of what the next state implies.
        lastD = (stateD == StTurn && cntD == 4'd0) ||
                (!HasTurn && stateD == StDrive && cntD == 4'd0);
        busyD = (stateD != StIdle);
        doneD = lastD && !abortedD;
        oe1D  = !(stateD == StDrive && grpD[0]);
        oe2D  = !(stateD == StDrive && grpD[1]);
    end

    // Reset clears the enable registers asynchronously, so both groups release at once.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stateQ   <= StIdle;
            cntQ     <= 4'd0;
            grpQ     <= 2'b00;
            drvQ     <= 8'h00;
            abortedQ <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            oe1Q     <= 1'b1;
            oe2Q     <= 1'b1;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            grpQ     <= grpD;
            drvQ     <= drvD;
            abortedQ <= abortedD;
            busyQ    <= busyD;
            doneQ    <= doneD;
            oe1Q     <= oe1D;
            oe2Q     <= oe2D;
        end
    end

    assign busy  = busyQ;
    assign done  = doneQ;
    assign drv_a = drvQ;
    assign oe1_n = oe1Q;
    assign oe2_n = oe2Q;
`ifdef BUS_DRV_ABORT_EN
    assign aborted = abortedQ;
`endif

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// Testbench for bus_drive_sequencer with the default parameters (DRIVE_CYCLES=2, TURN_CYCLES=1).
// The stimulus pushes one expected transaction per accepted request. On every done pulse, the
// monitor pops the expected transaction and compares it with what it saw on the bus.
module tb_bus_drive_sequencer;

    logic       sysclk = 1'b0;
    logic       sys_rst_n;
    logic       req;
    logic [7:0] data_in;
    logic [1:0] grp_sel;
    logic       busy;
    logic       done;
    logic [7:0] drv_a;
    logic       oe1_n;
    logic       oe2_n;
`ifdef BUS_DRV_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    bus_drive_sequencer dut (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .data_in   (data_in),
        .grp_sel   (grp_sel),
`ifdef BUS_DRV_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .busy      (busy),
        .done      (done),
        .drv_a     (drv_a),
        .oe1_n     (oe1_n),
        .oe2_n     (oe2_n)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] grp;
        int         lowCycles;   // cycles with at least one enable low
        int         bothCycles;  // cycles with both enables low together
    } expT;

    expT expQ[$];
    int  nChecks = 0;
    int  nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic stepEdge();
        @(posedge sysclk);
        #1;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            stepEdge();
            n++;
        end
        if (n >= 50) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    // Monitor: it measures each transaction's enable activity and checks it on the done pulse.
    int         lowCnt  = 0;
    int         bothCnt = 0;
    logic [1:0] maskSeen = 2'b00;
    always @(negedge sysclk) begin
        expT e;
        if (!sys_rst_n || !busy) begin
            lowCnt   = 0;
            bothCnt  = 0;
            maskSeen = 2'b00;
        end else begin
            if (!oe1_n || !oe2_n) lowCnt++;
            if (!oe1_n && !oe2_n) bothCnt++;
            maskSeen = maskSeen | {~oe2_n, ~oe1_n};
            if (done) begin
                if (expQ.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    check("sb_drv_a", 32'(drv_a), 32'(e.data));
                    check("sb_grp_mask", 32'(maskSeen), 32'(e.grp));
                    check("sb_low_cycles", 32'(lowCnt), 32'(e.lowCycles));
                    check("sb_both_cycles", 32'(bothCnt), 32'(e.bothCycles));
                    check("sb_oe_released", 32'({oe2_n, oe1_n}), 32'h3);
                end
            end
        end
    end

    initial begin
        expT e;
        sys_rst_n = 1'b0;
        req       = 1'b0;
        data_in   = 8'h00;
        grp_sel   = 2'b00;
`ifdef BUS_DRV_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) stepEdge();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drv_a", 32'(drv_a), 32'h00);
        check("rst_oe", 32'({oe2_n, oe1_n}), 32'h3);
        sys_rst_n = 1'b1;
        stepEdge();

        // Group 1 only, byte A5: a cycle-by-cycle timing check.
        e = '{data: 8'hA5, grp: 2'b01, lowCycles: 2, bothCycles: 0};
        expQ.push_back(e);
        req = 1'b1; data_in = 8'hA5; grp_sel = 2'b01;
        stepEdge();                                   // edge 1: accept
        req = 1'b0; data_in = 8'h00; grp_sel = 2'b00;
        check("a5_e1_drv_a", 32'(drv_a), 32'hA5);
        check("a5_e1_busy", 32'(busy), 32'd1);
        check("a5_e1_oe", 32'({oe2_n, oe1_n}), 32'h3);
        stepEdge();                                   // edge 2
        check("a5_e2_oe", 32'({oe2_n, oe1_n}), 32'h2);
        stepEdge();                                   // edge 3
        check("a5_e3_oe", 32'({oe2_n, oe1_n}), 32'h2);
        check("a5_e3_done", 32'(done), 32'd0);
        stepEdge();                                   // edge 4
        check("a5_e4_oe", 32'({oe2_n, oe1_n}), 32'h3);
        check("a5_e4_done", 32'(done), 32'd1);
        check("a5_e4_busy", 32'(busy), 32'd1);
        stepEdge();                                   // edge 5
        check("a5_e5_busy", 32'(busy), 32'd0);
        check("a5_e5_done", 32'(done), 32'd0);
        check("a5_e5_drv_hold", 32'(drv_a), 32'hA5);

        // Both groups, byte 3C.
        e = '{data: 8'h3C, grp: 2'b11, lowCycles: 2, bothCycles: 2};
        expQ.push_back(e);
        req = 1'b1; data_in = 8'h3C; grp_sel = 2'b11;
        stepEdge();
        req = 1'b0;
        check("3c_drv_a", 32'(drv_a), 32'h3C);
        stepEdge();
        check("3c_oe_both_low", 32'({oe2_n, oe1_n}), 32'h0);
        waitIdle("3c");
        check("3c_drv_hold", 32'(drv_a), 32'h3C);

        // No group selected: the request is ignored.
        req = 1'b1; data_in = 8'hFF; grp_sel = 2'b00;
        repeat (4) begin
            stepEdge();
            check("nogrp_busy", 32'(busy), 32'd0);
            check("nogrp_oe", 32'({oe2_n, oe1_n}), 32'h3);
        end
        check("nogrp_drv_a", 32'(drv_a), 32'h3C);

        // req held high: back-to-back transactions with one idle cycle between them.
        e = '{data: 8'h11, grp: 2'b10, lowCycles: 2, bothCycles: 0};
        expQ.push_back(e);
        e = '{data: 8'h22, grp: 2'b10, lowCycles: 2, bothCycles: 0};
        expQ.push_back(e);
        data_in = 8'h11; grp_sel = 2'b10;
        stepEdge();                                   // accept 11
        data_in = 8'h22;
        check("b2b_first_drv_a", 32'(drv_a), 32'h11);
        stepEdge();
        check("b2b_ignored_while_busy", 32'(drv_a), 32'h11);
        check("b2b_oe2_low", 32'({oe2_n, oe1_n}), 32'h1);
        repeat (3) stepEdge();                        // edge 5: back in IDLE
        check("b2b_gap_busy", 32'(busy), 32'd0);
        check("b2b_gap_drv_a", 32'(drv_a), 32'h11);
        stepEdge();                                   // accept 22
        req = 1'b0;
        check("b2b_second_busy", 32'(busy), 32'd1);
        check("b2b_second_drv_a", 32'(drv_a), 32'h22);
        waitIdle("b2b");

`ifdef BUS_DRV_ABORT_EN
        // Abort during the first DRIVE cycle: one TURN cycle, no done, sticky aborted.
        req = 1'b1; data_in = 8'h5A; grp_sel = 2'b01;
        stepEdge();
        req = 1'b0;
        stepEdge();                                   // first DRIVE cycle
        check("ab_oe_low", 32'(oe1_n), 32'd0);
        abort = 1'b1;
        stepEdge();
        abort = 1'b0;
        check("ab_oe_released", 32'({oe2_n, oe1_n}), 32'h3);
        check("ab_aborted", 32'(aborted), 32'd1);
        check("ab_busy_turn", 32'(busy), 32'd1);
        check("ab_no_done", 32'(done), 32'd0);
        stepEdge();
        check("ab_idle", 32'(busy), 32'd0);
        check("ab_sticky", 32'(aborted), 32'd1);
        e = '{data: 8'h66, grp: 2'b01, lowCycles: 2, bothCycles: 0};
        expQ.push_back(e);
        req = 1'b1; data_in = 8'h66; grp_sel = 2'b01;
        stepEdge();
        req = 1'b0;
        check("ab_cleared", 32'(aborted), 32'd0);
        waitIdle("ab_next");
`endif

        // Asynchronous reset during DRIVE releases everything before the next edge.
        e = '{data: 8'h77, grp: 2'b01, lowCycles: 2, bothCycles: 0};
        expQ.push_back(e);
        req = 1'b1; data_in = 8'h77; grp_sel = 2'b01;
        stepEdge();
        req = 1'b0;
        stepEdge();
        check("rstmid_oe_low", 32'(oe1_n), 32'd0);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rstmid_oe", 32'({oe2_n, oe1_n}), 32'h3);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_drv_a", 32'(drv_a), 32'h00);
        void'(expQ.pop_back());                       // that transaction never completes
        repeat (2) stepEdge();
        sys_rst_n = 1'b1;
        repeat (3) stepEdge();
        check("rstmid_stays_idle", 32'(busy), 32'd0);

        check("sb_queue_empty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
